// File: rtl/cpu_clk_ctrl.sv
// Clock-enable generator pacing the CPU: full speed, 2^n divided rate, single-step or halt,
// plus a free-running display-scan enable and a wrapping count of issued CPU enables.
module cpu_clk_ctrl #(
  parameter int CNT_W    = 32,
  parameter int DIV_BASE = 20,
  parameter int SCAN_DIV = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [2:0]  div_sel,
  input  logic        step_btn,
  output logic        cpu_ce,
  output logic        scan_ce,
  output logic [1:0]  cur_mode,
  output logic [31:0] ce_count
);

  typedef enum logic [1:0] {
    ST_FULL = 2'b00,
    ST_DIV  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SCAN_DIV-1:0] SCAN_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [2:0]          div_sel_q, div_sel_d;
  logic                btn_prev_q, btn_prev_d;
  logic                cpu_ce_q, cpu_ce_d;
  logic [SCAN_DIV-1:0] scan_cnt_q;
  logic                scan_ce_q;
  logic [31:0]         ce_count_q;
  logic [CNT_W-1:0]    period_m1;

  assign period_m1 = (CNT_ONE << (DIV_BASE + int'(div_sel_q))) - CNT_ONE;

  // Mode change outranks a div_sel change, which outranks the per-state action.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_sel_d  = div_sel_q;
    btn_prev_d = btn_prev_q;
    cpu_ce_d   = 1'b0;
    if (mode != state_q) begin
      state_d    = state_e'(mode);
      div_cnt_d  = '0;
      btn_prev_d = step_btn;
    end else if (div_sel != div_sel_q) begin
      div_sel_d = div_sel;
      div_cnt_d = '0;
    end else begin
      case (state_q)
        ST_FULL: cpu_ce_d = 1'b1;
        ST_DIV: begin
          if (div_cnt_q == period_m1) begin
            div_cnt_d = '0;
            cpu_ce_d  = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + CNT_ONE;
          end
        end
        ST_STEP: begin
          btn_prev_d = step_btn;
          cpu_ce_d   = step_btn & ~btn_prev_q;
        end
        default: div_cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HALT;
      div_cnt_q  <= '0;
      div_sel_q  <= div_sel;
      btn_prev_q <= step_btn;
      cpu_ce_q   <= 1'b0;
      scan_cnt_q <= '0;
      scan_ce_q  <= 1'b0;
      ce_count_q <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_sel_q  <= div_sel_d;
      btn_prev_q <= btn_prev_d;
      cpu_ce_q   <= cpu_ce_d;
      scan_cnt_q <= scan_cnt_q + SCAN_ONE;
      scan_ce_q  <= &scan_cnt_q;
      if (cpu_ce_q) ce_count_q <= ce_count_q + 32'd1;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign scan_ce  = scan_ce_q;
  assign cur_mode = state_q;
  assign ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with DIV_BASE=2, SCAN_DIV=3; a reference model queues the
// expected outputs of every edge, popped and compared after that edge, plus directed spot checks.
module tb_cpu_clk_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [2:0]  div_sel;
  logic        step_btn;
  logic        cpu_ce;
  logic        scan_ce;
  logic [1:0]  cur_mode;
  logic [31:0] ce_count;

  int vectors = 0;
  int miscompares = 0;

  cpu_clk_ctrl #(.CNT_W(16), .DIV_BASE(2), .SCAN_DIV(3)) dut (
    .clk(clk), .reset(reset), .mode(mode), .div_sel(div_sel), .step_btn(step_btn),
    .cpu_ce(cpu_ce), .scan_ce(scan_ce), .cur_mode(cur_mode), .ce_count(ce_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [1:0]  m_mode;
  logic [2:0]  m_sel;
  logic        m_prev, m_ce, m_scan_ce;
  logic [31:0] m_cnt;
  int unsigned m_phase;
  int          m_scan;
  logic [35:0] exp_q[$];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int unsigned p;
    p = 32'd1 << (2 + int'(m_sel));
    if (reset) begin
      m_mode = 2'b11; m_ce = 1'b0; m_cnt = '0; m_phase = 0;
      m_scan = 0; m_scan_ce = 1'b0; m_sel = div_sel; m_prev = step_btn;
    end else begin
      m_cnt     = m_cnt + {31'b0, m_ce};
      m_scan_ce = (m_scan == 7);
      m_scan    = (m_scan + 1) % 8;
      if (mode != m_mode) begin
        m_mode = mode; m_phase = 0; m_ce = 1'b0; m_prev = step_btn;
      end else if (div_sel != m_sel) begin
        m_sel = div_sel; m_phase = 0; m_ce = 1'b0;
      end else begin
        case (m_mode)
          2'b00: m_ce = 1'b1;
          2'b01: begin
            m_phase++;
            m_ce = (m_phase == p);
            if (m_ce) m_phase = 0;
          end
          2'b10: begin
            m_ce   = step_btn & ~m_prev;
            m_prev = step_btn;
          end
          default: m_ce = 1'b0;
        endcase
      end
    end
    exp_q.push_back({m_ce, m_scan_ce, m_mode, m_cnt});
  endtask

  task automatic step();
    logic [35:0] e;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("edge", {cpu_ce, scan_ce, cur_mode, ce_count}, e);
  endtask

  initial begin
    int first, pulses, scans;
    reset = 1'b1; mode = 2'b11; div_sel = 3'd0; step_btn = 1'b0;
    step(); step();
    chk("reset_state", {32'b0, cpu_ce, scan_ce, cur_mode}, {32'b0, 1'b0, 1'b0, 2'b11});

    // HALT for 20 cycles: scan pulses at cycles 8 and 16 only
    reset = 1'b0;
    first = 0; scans = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (scan_ce === 1'b1) begin
        scans++;
        if (first == 0) first = i;
      end
    end
    chk("halt_scan_first", 36'(first), 36'd8);
    chk("halt_scan_count", 36'(scans), 36'd2);
    chk("halt_count", {2'b0, cur_mode, ce_count}, {2'b0, 2'b11, 32'd0});

    // FULL
    mode = 2'b00;
    step();
    chk("full_transition_ce", 36'(cpu_ce), 36'd0);
    for (int i = 1; i <= 11; i++) step();
    chk("full_count10", 36'(ce_count), 36'd10);
    for (int i = 12; i <= 38; i++) step();
    chk("full_count37", 36'(ce_count), 36'd37);

    // Reset mid-FULL; DIV P=8 selected under reset
    reset = 1'b1; mode = 2'b01; div_sel = 3'd1;
    step();
    chk("midreset", {cpu_ce, 1'b0, cur_mode, ce_count}, {1'b0, 1'b0, 2'b11, 32'd0});
    reset = 1'b0;
    step();
    first = 0; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (cpu_ce === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("div8_first", 36'(first), 36'd8);
    chk("div8_pulses", 36'(pulses), 36'd2);

    // div_sel to 0 mid-period: next pulse 4 cycles after the change edge
    div_sel = 3'd0;
    step();
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (cpu_ce === 1'b1 && first == 0) first = i;
    end
    chk("div4_first", 36'(first), 36'd4);

    // At div_cnt = P-2, switch to HALT: no pulse ever
    step(); step();
    mode = 2'b11;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cpu_ce === 1'b1) pulses++;
    end
    chk("halt_no_pulse", 36'(pulses), 36'd0);
    mode = 2'b01;
    step();
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (cpu_ce === 1'b1 && first == 0) first = i;
    end
    chk("div_reentry_first", 36'(first), 36'd4);

    // STEP with button held at entry
    mode = 2'b10; step_btn = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (cpu_ce === 1'b1) pulses++;
    end
    chk("step_held_entry", 36'(pulses), 36'd0);
    step_btn = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    step_btn = 1'b1;
    first = 0; pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (cpu_ce === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("step_one_pulse", 36'(pulses), 36'd1);
    chk("step_pulse_pos", 36'(first), 36'd1);
    pulses = 0;
    for (int n = 0; n < 3; n++) begin
      step_btn = 1'b0;
      step(); step();
      if (cpu_ce === 1'b1) pulses++;
      step_btn = 1'b1;
      step();
      if (cpu_ce === 1'b1) pulses++;
      step();
      if (cpu_ce === 1'b1) pulses++;
    end
    step_btn = 1'b0;
    step();
    chk("step_three_presses", 36'(pulses), 36'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
